// File: rtl/mem_bus_master.sv
// mem_bus_master: single-word load/store initiator for the shared 256-bit
// tristate memory bus (7 memory words plus the result register at address 7).
// A load takes three cycles (address, capture, response), a store two
// (drive, response). All bus outputs are registered; only req_ready and the
// dataBus drive enable are decoded from the state.
// Optional feature macro: MEMBUS_PERF_CNT_EN adds saturating 16-bit
// completed-load / completed-store counters; without it both ports are 0.
module mem_bus_master (
    input  logic         clk,
    input  logic         Reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [2:0]   req_addr,
    input  logic [255:0] req_wdata,
    output logic         rsp_valid,
    output logic [255:0] rsp_rdata,
    output logic [2:0]   address,
    output logic         nEnable,
    output logic         ReadWrite,
    inout  wire  [255:0] dataBus,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_CAP  = 2'd2,
        WR_DRV  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           accept;
    logic [255:0]   wdata;
    logic           nen_nxt;
    logic           rw_nxt;
    logic [2:0]     addr_nxt;
    logic           rsp_valid_nxt;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // The master owns the bus only during the single store-drive cycle.
    assign dataBus = (state == WR_DRV) ? wdata : 'z;

    // State register; Reset aborts any operation back to IDLE.
    always_ff @(posedge clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state sequencing of the load and store bus cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_write ? WR_DRV : RD_ADDR;
            RD_ADDR: state_nxt = RD_CAP;
            RD_CAP:  state_nxt = IDLE;
            WR_DRV:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so bus outputs can be registered.
    always_comb begin
        nen_nxt       = 1'b1;
        rw_nxt        = 1'b1;
        addr_nxt      = address;
        rsp_valid_nxt = (state == RD_CAP) || (state == WR_DRV);
        if (accept)
            addr_nxt = req_addr;
        case (state_nxt)
            RD_ADDR, RD_CAP: nen_nxt = 1'b0;
            WR_DRV: begin
                nen_nxt = 1'b0;
                rw_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered bus/response outputs; load data is captured leaving RD_CAP.
    always_ff @(posedge clk) begin
        if (Reset) begin
            nEnable   <= 1'b1;
            ReadWrite <= 1'b1;
            address   <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            nEnable   <= nen_nxt;
            ReadWrite <= rw_nxt;
            address   <= addr_nxt;
            rsp_valid <= rsp_valid_nxt;
            if (state == RD_CAP)
                rsp_rdata <= dataBus;
        end
    end

    // Store data latched at acceptance; it is only observed while in WR_DRV.
    always_ff @(posedge clk) begin
        if (accept)
            wdata <= req_wdata;
    end

`ifdef MEMBUS_PERF_CNT_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    // Saturating completion counters, stepped on the response edge.
    always_ff @(posedge clk) begin
        if (Reset) begin
            rd_cnt <= 16'h0000;
            wr_cnt <= 16'h0000;
        end else begin
            if (state == RD_CAP && rd_cnt != 16'hFFFF)
                rd_cnt <= rd_cnt + 16'd1;
            if (state == WR_DRV && wr_cnt != 16'hFFFF)
                wr_cnt <= wr_cnt + 16'd1;
        end
    end

    assign rd_count = rd_cnt;
    assign wr_count = wr_cnt;
`else
    assign rd_count = 16'h0000;
    assign wr_count = 16'h0000;
`endif

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus initiator for the shared 256-bit tristate memory bus. It accepts single-word load/store requests from the engine control path and sequences `address`, `nEnable`, `ReadWrite` and `dataBus` cycles against the 7-entry memory and the result register at address 7. On reads it returns the captured word on a response port. On writes it drives the bus for exactly one cycle and then acknowledges.

## Interface
- No parameters. Data width is fixed at 256 bits; address width is fixed at 3 bits.
- `clk`  input  1  clock, rising-edge logic.
- `Reset`  input  1  reset: synchronous, active-high.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  block can accept a request; high only in IDLE.
- `req_write`  input  1  1 = store, 0 = load.
- `req_addr`  input  3  target address, 0–7.
- `req_wdata`  input  256  store data.
- `rsp_valid`  output  1  one-cycle pulse; load data valid or store complete.
- `rsp_rdata`  output  256  last captured load word; held between loads.
- `address`  output  3  memory address.
- `nEnable`  output  1  active-low bus enable.
- `ReadWrite`  output  1  1 = read, 0 = write.
- `dataBus`  inout  256  shared bus; driven only in WR_DRV, otherwise `'z`.
- `rd_count`  output  16  completed loads; see Configuration.
- `wr_count`  output  16  completed stores; see Configuration.

## Operation
- A request is accepted on a rising edge where `req_valid && req_ready`. At acceptance, `req_write`, `req_addr` and `req_wdata` are latched. Inputs are don't-care after that edge.
- IDLE:
  - `nEnable`=1, bus released, `req_ready`=1.
  - Accepted load → RD_ADDR. Accepted store → WR_DRV.
- RD_ADDR:
  - `nEnable`=0, `ReadWrite`=1, `address`=latched address.
  - The memory loads its output register at the next edge → RD_CAP.
- RD_CAP:
  - Same outputs as RD_ADDR; the memory drives the bus.
  - At the next edge: `rsp_rdata`←`dataBus`, `rsp_valid`=1 for one cycle → IDLE.
- WR_DRV:
  - `nEnable`=0, `ReadWrite`=0, `address`=latched address, `dataBus`=latched data.
  - The memory writes on the falling edge mid-cycle. At the next edge: bus released, `rsp_valid`=1 for one cycle → IDLE.
- Address 7:
  - Issued identically to other addresses; the result register owns that slot.
  - A load from 7 with no result-register driver captures whatever is on the bus. No error is raised.
- `rsp_rdata` is unchanged by stores.
- Reset values: state IDLE, `nEnable`=1, `ReadWrite`=1, `address`=0, `dataBus`=z, `rsp_valid`=0, `rsp_rdata`=0, `req_ready`=1 in the cycle after the Reset edge, both counters 0.
- Reset asserted mid-operation:
  - Aborts at that edge: → IDLE, bus released, no `rsp_valid`.
  - A store aborted after its falling edge has already written the memory. This is accepted behaviour.

## Timing
- Load accepted at edge k:
  - RD_ADDR during k..k+1; RD_CAP during k+1..k+2.
  - Data captured at edge k+2; `rsp_valid` high during k+2..k+3.
  - Next accept no earlier than edge k+3, so one load per 3 cycles.
- Store accepted at edge k:
  - Bus driven during k..k+1; `rsp_valid` high during k+1..k+2.
  - Next accept at edge k+2, so one store per 2 cycles.
- `nEnable` is high for at least one full cycle between consecutive operations. There is no bus contention between the master and the memory on read/write turnaround.
- All outputs are registered, except `req_ready` (decoded from state) and the `dataBus` enable (decoded from state).

## Configuration
- `MEMBUS_PERF_CNT_EN` defined:
  - `rd_count` increments at each load's `rsp_valid` edge; `wr_count` increments at each store's `rsp_valid` edge.
  - Both are 16-bit, saturate at 16'hFFFF and are cleared by `Reset`.
- `MEMBUS_PERF_CNT_EN` undefined: counter logic is omitted and both ports are tied to 16'h0000.

## Test plan
- Memory reset, then load addr 0 accepted at edge k → `rsp_valid` at edge k+2 with `rsp_rdata`=256'h0004_000c_0004_0022_0007_0006_000b_0009_0009_0002_0008_000d_0002_000f_0010_0003.
- Store 256'h1234…(pattern) to addr 3, then load addr 3:
  - Store cycle has `nEnable`=0, `ReadWrite`=0 for exactly one cycle; `rsp_valid` follows one cycle after accept.
  - Load returns the same pattern.
  - `rsp_rdata` is unchanged during the store.
- `req_valid` held high with alternating load/store:
  - Accept edges spaced 3 (load) and 2 (store) cycles apart; `nEnable`=1 between operations.
  - Monitor asserts that `dataBus` is never driven by both master and memory.
- Reset pulsed during RD_CAP → no `rsp_valid`, `nEnable`=1 and `rsp_rdata`=0 on the next cycle, `req_ready`=1 on the following cycle.
- Load addr 2 → `rsp_rdata` = instruction word 256'h28_31_5b_2b_30_7c_2c_dd_2d_88_3f_2f_35_be_00…00.
- With `MEMBUS_PERF_CNT_EN`: 5 loads + 3 stores → `rd_count`=5, `wr_count`=3. Forced to 16'hFFFF → stays at 16'hFFFF after another load. Without the macro → both read 0.
